// File: rtl/param_tick_counter.sv
// Prescaled up/down counter over 0..MAX, stepping once every DIV clk cycles while enabled.
// Latency: count/tick/tc registered, one cycle after the sampling edge; first step on the DIV-th edge.
// Backpressure: none; en=0 freezes prescaler and count, clear/load preempt a coinciding step.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous active-low reset
//   en        run enable (freezes prescaler and count when low)
//   up        direction, 1 = up, 0 = down
//   load      synchronous load of load_val (clamped to MAX)
//   load_val  value to load
//   clear     synchronous clear to 0 (wins over load)
//   sat_mode  1 = saturate at limits, 0 = wrap (only honoured with PCNT_SAT_EN)
//   count     current count
//   tick      one-cycle pulse on each count step
//   tc        one-cycle pulse when a step starts at the terminal value
//
// Build option: define PCNT_SAT_EN to enable saturation; otherwise the counter always wraps.
module param_tick_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15,
    parameter int DIV   = 50_000_000,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    // With DIV=1 the one-bit prescaler sits at 0, which is also DIV-1,
    // so every enabled cycle is a step without a special case.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT);

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             step;
    logic             sat;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;

`ifdef PCNT_SAT_EN
    assign sat = sat_mode;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat             = 1'b0;
`endif

    assign div_last     = (div_cnt == DIV_LAST);
    assign step         = en && div_last && !clear && !load;
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Terminal value follows the direction sampled on the step edge.
    assign at_term = up ? (count == MAX_V) : (count == '0);

    always_comb begin
        count_nxt = count;
        if (at_term) begin
            if (!sat) begin
                count_nxt = up ? '0 : MAX_V;
            end
        end else begin
            count_nxt = up ? (count + 1'b1) : (count - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= INIT_V;
            div_cnt <= '0;
            tick    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            tick <= step;
            tc   <= step && at_term;
            if (clear) begin
                count   <= '0;
                div_cnt <= '0;
            end else if (load) begin
                count   <= load_clamped;
                div_cnt <= '0;
            end else begin
                if (en) begin
                    div_cnt <= div_last ? '0 : (div_cnt + 1'b1);
                end
                if (step) begin
                    count <= count_nxt;
                end
            end
        end
    end

endmodule
